// File: rtl/fixed_to_fp_pkg.sv
// Shared constants and stage-register layouts for the fixed-point to
// IEEE-754 single-precision conversion pipeline.
package fixed_to_fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // Stage registers are sized for the widest legal magnitude (32 bits).
    localparam int MAG_MAX_W = 32;
    localparam int POS_MAX_W = 5;

    // S1: leading-one position of the magnitude.
    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic                 zero;
        logic [POS_MAX_W-1:0] pos;
        logic [MAG_MAX_W-1:0] mag;
    } s1_t;

    // S2: normalised mantissa with guard and sticky.
    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic                 zero;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
        logic                 guard;
        logic                 sticky;
    } s2_t;

    // S3: packed result.
    typedef struct packed {
        logic        valid;
        logic [31:0] fp;
        logic        inexact;
    } s3_t;

endpackage

// File: rtl/fixed_to_fp_pipe_lod.sv
// Combinational leading-one detector: index of the highest set bit.
module fixed_lod #(
    parameter int W     = 20,
    parameter int POS_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     in_i,
    output logic [POS_W-1:0] pos_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        pos_o  = '0;
        zero_o = 1'b1;
        for (int unsigned i = 0; i < unsigned'(W); i++) begin
            if (in_i[i]) begin
                pos_o  = POS_W'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fixed_to_fp_pipe.sv
// Three-stage unsigned-magnitude fixed-point to IEEE-754 single converter
// with a global stall driven by downstream ready.
module fixed_to_fp_pipe
    import fixed_to_fp_pkg::*;
#(
    parameter int INT_W    = 1,
    parameter int FRAC_W   = 19,
    parameter int ROUND_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sign_i,
    input  logic [INT_W-1:0]  int_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       fp_o,
    output logic              inexact_o
);

    localparam int W     = INT_W + FRAC_W;
    localparam int POS_W = (W > 1) ? $clog2(W) : 1;

    if (INT_W < 1 || INT_W > 16 || W < 2 || W > 32) begin : g_bad_width
        $error("fixed_to_fp_pipe: INT_W must be 1..16 and INT_W+FRAC_W 2..32");
    end

    if (ROUND_EN != 0 && ROUND_EN != 1) begin : g_bad_round
        $error("fixed_to_fp_pipe: ROUND_EN must be 0 or 1");
    end

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic             adv;
    logic [W-1:0]     mag;
    logic [POS_W-1:0] lod_pos;
    logic             lod_zero;

    assign adv     = !s3_q.valid || ready_i;
    assign ready_o = adv;
    assign mag     = {int_i, frac_i};

    assign valid_o   = s3_q.valid;
    assign fp_o      = s3_q.fp;
    assign inexact_o = s3_q.inexact;

    fixed_lod #(
        .W(W)
    ) u_lod (
        .in_i  (mag),
        .pos_o (lod_pos),
        .zero_o(lod_zero)
    );

    // S1: capture magnitude with its leading-one position.
    always_comb begin
        s1_d = s1_q;
        if (adv) begin
            s1_d.valid = valid_i;
            s1_d.sign  = sign_i;
            s1_d.zero  = lod_zero;
            s1_d.pos   = POS_MAX_W'(lod_pos);
            s1_d.mag   = MAG_MAX_W'(mag);
        end
    end

    // S2: shift the leading one to bit 31 and drop it; the 31 bits below
    // split into mantissa, guard and sticky. For p <= 23 all low bits
    // shift into the mantissa, so guard and sticky are zero.
    logic [30:0] norm;

    always_comb begin
        norm = 31'(s1_q.mag << (5'd31 - s1_q.pos));
        s2_d = s2_q;
        if (adv) begin
            s2_d.valid  = s1_q.valid;
            s2_d.sign   = s1_q.sign;
            s2_d.zero   = s1_q.zero;
            s2_d.exp    = 8'(FP_BIAS - FRAC_W) + {3'b000, s1_q.pos};
            s2_d.mant   = norm[30:8];
            s2_d.guard  = norm[7];
            s2_d.sticky = |norm[6:0];
        end
    end

    // S3: round (nearest-even or truncate) and pack; a mantissa carry
    // leaves the mantissa at zero and bumps the exponent.
    logic        inc;
    logic [23:0] mant_sum;
    logic [7:0]  exp_r;

    always_comb begin
        inc      = (ROUND_EN != 0) && s2_q.guard && (s2_q.sticky || s2_q.mant[0]);
        mant_sum = {1'b0, s2_q.mant} + {23'b0, inc};
        exp_r    = s2_q.exp + {7'b0, mant_sum[23]};
        s3_d     = s3_q;
        if (adv) begin
            s3_d.valid = s2_q.valid;
            if (s2_q.zero) begin
                s3_d.fp      = FP_POS_ZERO;
                s3_d.inexact = 1'b0;
            end else begin
                s3_d.fp      = {s2_q.sign, exp_r, mant_sum[22:0]};
                s3_d.inexact = s2_q.guard || s2_q.sticky;
            end
        end
    end

    // Stage registers; reset discards anything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop and
// compare whenever an output is presented.
module tb_fixed_to_fp_pipe;

    typedef struct {
        logic [31:0] fp;
        logic        inx;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic ready_i = 1'b1;
    logic bp_en = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Default-parameter instance.
    logic        v0_i = 1'b0, s0_i = 1'b0, i0_i = 1'b0;
    logic [18:0] f0_i = '0;
    logic        ready0_o, valid0_o, inx0_o;
    logic [31:0] fp0_o;

    // 8.24 instances, rounding and truncating, driven in parallel.
    logic        v8_i = 1'b0, s8_i = 1'b0;
    logic [7:0]  i8_i = '0;
    logic [23:0] f8_i = '0;
    logic        ready1_o, valid1_o, inx1_o;
    logic        ready2_o, valid2_o, inx2_o;
    logic [31:0] fp1_o, fp2_o;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    fixed_to_fp_pipe dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v0_i), .ready_o(ready0_o),
        .sign_i(s0_i), .int_i(i0_i), .frac_i(f0_i), .valid_o(valid0_o),
        .ready_i(ready_i), .fp_o(fp0_o), .inexact_o(inx0_o)
    );

    fixed_to_fp_pipe #(.INT_W(8), .FRAC_W(24), .ROUND_EN(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v8_i), .ready_o(ready1_o),
        .sign_i(s8_i), .int_i(i8_i), .frac_i(f8_i), .valid_o(valid1_o),
        .ready_i(ready_i), .fp_o(fp1_o), .inexact_o(inx1_o)
    );

    fixed_to_fp_pipe #(.INT_W(8), .FRAC_W(24), .ROUND_EN(0)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v8_i), .ready_o(ready2_o),
        .sign_i(s8_i), .int_i(i8_i), .frac_i(f8_i), .valid_o(valid2_o),
        .ready_i(ready_i), .fp_o(fp2_o), .inexact_o(inx2_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Downstream ready: pseudo-random while backpressure is enabled.
    always @(posedge clk) begin
        #1;
        ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor for the default instance, including ready/stall rules.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            chk("ready0_rule", 32'(ready0_o), 32'(!valid0_o || ready_i));
            if (valid0_o) begin
                if (q0.size() == 0) begin
                    chk("out0_unexpected", fp0_o, 32'hDEAD_BEEF);
                end else begin
                    e = q0[0];
                    chk("fp0", fp0_o, e.fp);
                    chk("inexact0", 32'(inx0_o), 32'(e.inx));
                    if (ready_i) begin
                        if (e.cyc >= 0) chk("latency0", cyc, e.cyc);
                        void'(q0.pop_front());
                    end
                end
            end
        end
    end

    // Monitor for the two 8.24 instances.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            chk("ready1_rule", 32'(ready1_o), 32'(!valid1_o || ready_i));
            chk("ready2_rule", 32'(ready2_o), 32'(!valid2_o || ready_i));
            if (valid1_o) begin
                if (q1.size() == 0) begin
                    chk("out1_unexpected", fp1_o, 32'hDEAD_BEEF);
                end else if (ready_i) begin
                    e = q1.pop_front();
                    chk("fp1_round", fp1_o, e.fp);
                    chk("inexact1", 32'(inx1_o), 32'(e.inx));
                    chk("latency1", cyc, e.cyc);
                end
            end
            if (valid2_o) begin
                if (q2.size() == 0) begin
                    chk("out2_unexpected", fp2_o, 32'hDEAD_BEEF);
                end else if (ready_i) begin
                    e = q2.pop_front();
                    chk("fp2_trunc", fp2_o, e.fp);
                    chk("inexact2", 32'(inx2_o), 32'(e.inx));
                    chk("latency2", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send0(input logic s, input logic i, input logic [18:0] f,
                         input logic [31:0] efp, input logic einx);
        exp_t e;
        int   tmo;
        @(negedge clk);
        s0_i = s;
        i0_i = i;
        f0_i = f;
        v0_i = 1'b1;
        tmo  = 0;
        while (!ready0_o && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 100) chk("send0_timeout", 32'(tmo), 32'd0);
        e.fp  = efp;
        e.inx = einx;
        e.cyc = bp_en ? -1 : cyc + 3;
        q0.push_back(e);
        @(posedge clk);
        #1 v0_i = 1'b0;
    endtask

    task automatic send8(input logic s, input logic [31:0] m,
                         input logic [31:0] efp1, input logic einx1,
                         input logic [31:0] efp2, input logic einx2);
        exp_t e;
        int   tmo;
        @(negedge clk);
        s8_i = s;
        i8_i = m[31:24];
        f8_i = m[23:0];
        v8_i = 1'b1;
        tmo  = 0;
        while (!(ready1_o && ready2_o) && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 100) chk("send8_timeout", 32'(tmo), 32'd0);
        e.cyc = cyc + 3;
        e.fp  = efp1;
        e.inx = einx1;
        q1.push_back(e);
        e.fp  = efp2;
        e.inx = einx2;
        q2.push_back(e);
        @(posedge clk);
        #1 v8_i = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_leftover", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #1;
        chk("rst_valid_o", 32'(valid0_o), 32'd0);
        chk("rst_fp_o", fp0_o, 32'd0);
        chk("rst_inexact_o", 32'(inx0_o), 32'd0);
        chk("rst_ready_o", 32'(ready0_o), 32'd1);
        @(posedge clk);
        #2 rst_i = 1'b0;

        // Default format, back to back.
        send0(1'b0, 1'b1, 19'h00000, 32'h3F80_0000, 1'b0);
        send0(1'b0, 1'b0, 19'h40000, 32'h3F00_0000, 1'b0);
        send0(1'b1, 1'b0, 19'h60000, 32'hBF40_0000, 1'b0);
        send0(1'b0, 1'b0, 19'h00001, 32'h3600_0000, 1'b0);
        send0(1'b1, 1'b0, 19'h00000, 32'h0000_0000, 1'b0);
        send0(1'b0, 1'b1, 19'h7FFFF, 32'h3FFF_FFF0, 1'b0);
        drain();

        // 8.24 format: rounding versus truncation.
        send8(1'b0, 32'h0100_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b1);
        send8(1'b0, 32'h0100_0003, 32'h3F80_0002, 1'b1, 32'h3F80_0001, 1'b1);
        send8(1'b0, 32'h01FF_FFFF, 32'h4000_0000, 1'b1, 32'h3FFF_FFFF, 1'b1);
        send8(1'b0, 32'h0000_0001, 32'h3380_0000, 1'b0, 32'h3380_0000, 1'b0);
        send8(1'b0, 32'h0080_0000, 32'h3F00_0000, 1'b0, 32'h3F00_0000, 1'b0);
        send8(1'b1, 32'hFFFF_FFFF, 32'hC380_0000, 1'b1, 32'hC37F_FFFF, 1'b1);
        send8(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        drain();

        // Backpressure: 1 + k/16 for k = 0..9.
        bp_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send0(1'b0, 1'b1, 19'(k << 15), 32'h3F80_0000 + 32'(k) * 32'h0008_0000, 1'b0);
        end
        bp_en = 1'b0;
        drain();

        // Reset with three conversions in flight.
        send0(1'b0, 1'b1, 19'h00000, 32'h3F80_0000, 1'b0);
        send0(1'b0, 1'b0, 19'h40000, 32'h3F00_0000, 1'b0);
        send0(1'b1, 1'b0, 19'h60000, 32'hBF40_0000, 1'b0);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_valid_o", 32'(valid0_o), 32'd0);
        chk("midrst_fp_o", fp0_o, 32'd0);
        chk("midrst_inexact_o", 32'(inx0_o), 32'd0);
        chk("midrst_ready_o", 32'(ready0_o), 32'd1);
        q0.delete();
        #1 rst_i = 1'b0;
        send0(1'b0, 1'b0, 19'h40000, 32'h3F00_0000, 1'b0);
        drain();
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_to_fp_pipe.md
FIXED_TO_FP_PIPE -- requirements
Module: fixed_to_fp_pipe

Interface
REQ-001 SHALL have parameter INT_W, default 1, meaning unsigned integer-magnitude bits (1..16).
REQ-002 SHALL have parameter FRAC_W, default 19, meaning fractional-magnitude bits; INT_W+FRAC_W SHALL be 2..32, otherwise elaboration error.
REQ-003 SHALL have parameter ROUND_EN, default 1, meaning 1 = round-to-nearest-even, 0 = truncate.
REQ-004 SHALL have ports in this order:
- clk_i  input  1  sole clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  input word valid.
- ready_o  output  1  block accepts input this cycle.
- sign_i  input  1  sign (1 = negative); the magnitude fields are unsigned.
- int_i  input  INT_W  integer magnitude.
- frac_i  input  FRAC_W  fractional magnitude.
- valid_o  output  1  fp_o valid.
- ready_i  input  1  downstream accepts fp_o.
- fp_o  output  32  IEEE-754 single result.
- inexact_o  output  1  result was rounded or truncated (nonzero discarded bits).

Function
REQ-005 Value SHALL be (-1)^sign_i * M * 2^-FRAC_W, with M = {int_i, frac_i} (width W = INT_W+FRAC_W).
REQ-006 Pipeline SHALL have 3 registered stages: S1 leading-one position p of M; S2 normalise M left so the leading one drops off, leaving a 23-bit mantissa plus guard and sticky bits; S3 round and pack.
REQ-007 Latency SHALL be exactly 3 clk_i cycles from an accepted input to valid_o when ready_i is held high.
REQ-008 Throughput SHALL be one conversion per cycle while ready_i = 1.
REQ-009 Global advance SHALL be adv = !valid_o | ready_i; ready_o SHALL equal adv combinationally.
- When adv = 0, every stage (data and valid) SHALL hold.
- Bubbles SHALL propagate as valid = 0.
REQ-010 An input SHALL be accepted only when valid_i & ready_o.
REQ-011 Once valid_o = 1, fp_o and inexact_o SHALL stay stable until valid_o & ready_i.
REQ-012 Exponent field SHALL be 127 + p - FRAC_W.
REQ-013 M = 0 SHALL give fp_o = 32'h0000_0000 (+0, sign dropped) and inexact_o = 0.
REQ-014 When p <= 23, there are no discarded bits: mantissa is exact and inexact_o = 0.
REQ-015 When p > 23, guard = bit p-24 and sticky = OR of bits below p-24.
- ROUND_EN = 1: increment the mantissa when guard & (sticky | mantissa LSB).
- ROUND_EN = 0: no increment.
REQ-016 A rounding carry out of the mantissa SHALL clear the mantissa and increment the exponent.
REQ-017 inexact_o SHALL be guard | sticky.
REQ-018 No denormal, infinity or NaN output is possible within REQ-002; none SHALL be generated.

Reset
REQ-019 rst_i high SHALL immediately clear every stage's valid and data registers: valid_o = 0, fp_o = 0, inexact_o = 0.
REQ-020 ready_o SHALL be 1 during reset (valid_o = 0).
REQ-021 In-flight conversions SHALL be discarded on reset and never emerge.
REQ-022 The first acceptance SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-023 Package fixed_to_fp_pkg SHALL hold:
- FP_BIAS = 127, FP_EXP_W = 8, FP_MANT_W = 23.
- FP_POS_ZERO.
- The stage-register struct typedefs.
REQ-024 Leading-one detection SHALL be a sub-module fixed_lod, parametrised by width, outputting position and zero flag (combinational).
REQ-025 No other sub-modules; RTL 120-400 lines.

Verification (defaults unless stated)
REQ-026 Conversions with ready_i = 1, each result 3 cycles later with inexact_o = 0:
- int=1, frac=0, sign=0 -> 32'h3F80_0000.
- int=0, frac=19'h40000 -> 32'h3F00_0000.
- sign=1, frac=19'h60000 -> 32'hBF40_0000.
- frac=19'h00001 -> 32'h3600_0000.
- int=0, frac=0, sign=1 -> 32'h0000_0000.
REQ-027 INT_W=8, FRAC_W=24, ROUND_EN=1:
- M=32'h0100_0001 -> 32'h3F80_0000, inexact_o = 1 (tie, round to even).
- M=32'h0100_0003 -> 32'h3F80_0002, inexact_o = 1.
- M=32'h01FF_FFFF -> 32'h4000_0000 (carry into exponent).
REQ-028 Same parameters as REQ-027 with ROUND_EN=0: M=32'h0100_0003 -> 32'h3F80_0001, inexact_o = 1.
REQ-029 Backpressure, 10 back-to-back inputs with ready_i toggled pseudo-randomly:
- Outputs appear in order, none lost or duplicated.
- fp_o stays stable while valid_o & !ready_i.
- ready_o = 0 only while valid_o & !ready_i.
REQ-030 Reset mid-stream with 3 conversions in flight:
- Pulse rst_i asynchronously between edges -> valid_o = 0 at once, no stale output afterwards.
- Next input (frac=19'h40000) -> 32'h3F00_0000 exactly 3 cycles after acceptance.
